ram_burst_reader: RTL and testbench

- Read-side controller for the 64x16 single-port LPM RAM (LPM_RAM_DQ, address registered on inclock, q registered on outclock, both on the same clock).
- Accepts a burst command (start address, word count) and drives the RAM address.
- Tracks the fixed 2-cycle read latency and delivers the words on a valid/ready stream with last-word marking.
- Includes a small skid FIFO, so consumer back-pressure never drops a word.

---
 rtl/ram_burst_reader_pkg.sv | 22 ++
 rtl/ram_burst_skid_fifo.sv | 54 +++++
 rtl/ram_burst_reader.sv | 173 +++++++++++++++++
 tb/tb_ram_burst_reader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM burst reader: FSM encoding, RAM geometry
// (common with myram), and the skid-FIFO sizing rule.
// No logic of its own; imported by ram_burst_reader and ram_burst_skid_fifo.
package ram_burst_reader_pkg;

  // Geometry of the 64x16 single-port RAM instance (myram)
  localparam int RAM_DATA_W = 16;
  localparam int RAM_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // The FIFO must be able to hold every read in flight plus the word at the head
  function automatic bit fifo_depth_ok(input int depth, input int rd_lat);
    return depth >= rd_lat + 1;
  endfunction

endpackage

// File: rtl/ram_burst_skid_fifo.sv
// Synchronous FIFO absorbing words already in flight from the RAM.
// Latency: a pushed word is visible at pop_data on the next cycle.
// Backpressure: push while full is accepted only together with a pop.
module ram_burst_skid_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = store[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read controller for the 64x16 LPM RAM, streaming words on valid/ready with last marking.
// Latency: first word valid RD_LAT+1 cycles after start is accepted, then one word per cycle.
// Backpressure: reads are issued only against free skid-FIFO slots, so a stalled consumer never loses a word.
// Optional RAM_BURST_ADDR_TAG_EN adds out_addr, the source address travelling with each word.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_W     = RAM_DATA_W,
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef RAM_BURST_ADDR_TAG_EN
  output logic [ADDR_W-1:0] out_addr,
`endif
  output logic              out_last
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LAT + 1);
`ifdef RAM_BURST_ADDR_TAG_EN
  localparam int ENT_W  = DATA_W + ADDR_W;
`else
  localparam int ENT_W  = DATA_W;
`endif

  if (!fifo_depth_ok(FIFO_DEPTH, RD_LAT)) begin : g_depth_check
    $error("ram_burst_reader: FIFO_DEPTH must be at least RD_LAT+1");
  end

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   addr_hold;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    dlv_cnt;
  logic [RD_LAT-1:0]   inflight;
  logic [OCC_W-1:0]    occ;
  logic                issue;
  logic                capture;
  logic                xfer;
  logic [ENT_W-1:0]    fifo_wdat;
  logic [ENT_W-1:0]    fifo_rdat;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FCNT_W-1:0]   fifo_count;

  // Words committed to the FIFO: already stored plus reads still in the RAM pipeline
  always_comb begin
    occ = OCC_W'(fifo_count);
    for (int i = 0; i < RD_LAT; i++) occ = occ + OCC_W'(inflight[i]);
  end

  // The RAM registers the address itself, so the pointer is presented directly in the issue cycle
  assign issue       = (state == ISSUE) && (issue_cnt != '0) && (occ < OCC_W'(FIFO_DEPTH));
  assign mem_address = issue ? ptr : addr_hold;
  assign mem_we      = 1'b0;
  assign capture     = inflight[RD_LAT-1];
  assign out_valid   = !fifo_empty;
  assign xfer        = out_valid && out_ready;
  assign out_last    = out_valid && (dlv_cnt == CNT_W'(1));
  assign out_data    = fifo_rdat[DATA_W-1:0];

  // In-flight marker: a 1 emerges exactly when the matching word is on mem_q
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      inflight[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) inflight[i] <= inflight[i-1];
    end
  end

`ifdef RAM_BURST_ADDR_TAG_EN
  logic [ADDR_W-1:0] tag_pipe [RD_LAT];

  // Source address travels alongside the in-flight marker
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= mem_address;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign fifo_wdat = {tag_pipe[RD_LAT-1], mem_q};
  assign out_addr  = fifo_rdat[ENT_W-1:DATA_W];
`else
  assign fifo_wdat = mem_q;
`endif

  // Control FSM with issue pointer, issue/deliver counters and registered busy/done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      addr_hold <= '0;
      issue_cnt <= '0;
      dlv_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        addr_hold <= ptr;
        ptr       <= ptr + ADDR_W'(1);
        issue_cnt <= issue_cnt - CNT_W'(1);
      end
      if (xfer && (dlv_cnt != '0)) dlv_cnt <= dlv_cnt - CNT_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (count != '0) begin
              ptr       <= start_addr;
              issue_cnt <= count;
              dlv_cnt   <= count;
              state     <= ISSUE;
            end else begin
              state <= FINISH;
            end
          end
        end
        ISSUE: begin
          if (issue && (issue_cnt == CNT_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (xfer && (dlv_cnt == CNT_W'(1))) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_burst_skid_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (capture),
    .push_data (fifo_wdat),
    .pop       (xfer),
    .pop_data  (fifo_rdat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A capture the FIFO cannot absorb means the credit accounting is broken
  assert property (@(posedge clock) disable iff (reset) !(capture && fifo_full && !xfer))
    else $error("ram_burst_reader: capture into full skid FIFO");

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a two-register LPM RAM model.
// Bursts come from a vector table; reset-abort is a hand-written sequence.
module tb_ram_burst_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  start_addr = '0;
  logic [6:0]  count = '0;
  logic        busy, done;
  logic [5:0]  mem_address;
  logic        mem_we;
  logic [15:0] mem_q;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
`ifdef RAM_BURST_ADDR_TAG_EN
  logic [5:0]  out_addr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ram_burst_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_q       (mem_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef RAM_BURST_ADDR_TAG_EN
    .out_addr    (out_addr),
`endif
    .out_last    (out_last)
  );

  always #5 clock = ~clock;

  // LPM_RAM_DQ model: registered address, registered q, same clock
  logic [15:0] ram [64];
  logic [5:0]  ram_addr_r = '0;
  always @(posedge clock) begin
    ram_addr_r <= mem_address;
    mem_q      <= ram[ram_addr_r];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d required finish", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [6:0]  cnt;
    logic [3:0]  rdy;      // out_ready pattern, bit k%4 used in cycle k
    logic [15:0] first_w;
    logic [15:0] last_w;
    bit          poke;     // pulse start mid-burst and in FINISH; both must be ignored
  } vec_t;

  vec_t vecs [7];

  // Runs one burst; k counts clock edges after the edge that samples start
  task automatic run_burst(input vec_t v);
    int idx, first_k, last_k, done_k, done_cnt, max_occ;
    bit stalled, valid_seen;
    logic [15:0] held_d, exp_w;
    logic held_l;
    logic [5:0] a;
    idx = 0; first_k = -1; last_k = -1; done_k = -1; done_cnt = 0; max_occ = 0;
    stalled = 0; valid_seen = 0; held_d = '0; held_l = 1'b0;
    @(negedge clock);
    start = 1'b1; start_addr = v.addr; count = v.cnt;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < 4 * v.cnt + 40; k++) begin
      if (v.poke && (k == 5 || (last_k >= 0 && k == last_k + 1))) begin
        start = 1'b1; start_addr = 6'd33; count = 7'd2;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        chk("busy_low_with_done", busy, 0);
      end
      if (done_k >= 0 && k == done_k + 1) chk("busy_idle_after_done", busy, 0);
      if (int'(dut.u_fifo.count) > max_occ) max_occ = int'(dut.u_fifo.count);
      out_ready = v.rdy[k % 4];
      if (out_valid) begin
        if (!valid_seen) begin valid_seen = 1; first_k = k; end
        if (stalled) begin
          chk("stall_data", out_data, held_d);
          chk("stall_last", out_last, held_l);
        end
      end
      if (out_valid && out_ready) begin
        if (idx >= v.cnt) chk("extra_word", idx, v.cnt);
        a = v.addr + 6'(idx);
        if (idx == 0) exp_w = v.first_w;
        else if (idx == v.cnt - 1) exp_w = v.last_w;
        else exp_w = 16'hA000 + {10'd0, a};
        chk("word_data", out_data, exp_w);
        chk("word_last", out_last, (idx == v.cnt - 1));
`ifdef RAM_BURST_ADDR_TAG_EN
        chk("word_addr", out_addr, a);
`endif
        idx++;
        if (idx == v.cnt) last_k = k;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1; held_d = out_data; held_l = out_last;
      end else begin
        stalled = 0;
      end
      if (done_k >= 0 && k == done_k + 1) break;
      @(negedge clock);
    end
    start = 1'b0;
    chk("word_count", idx, v.cnt);
    chk("done_pulses", done_cnt, 1);
    chk("occupancy_le_4", (max_occ <= 4), 1);
    if (v.cnt == 0) begin
      chk("zero_done_k", done_k, 1);
      chk("zero_no_valid", valid_seen, 0);
    end else begin
      chk("first_valid_k", first_k, 3);
      chk("done_after_last", done_k - last_k, 2);
      if (v.rdy == 4'b1111) chk("back_to_back", last_k - first_k, v.cnt - 1);
    end
  endtask

  initial begin
    int xf, dcnt, vcnt;
    vec_t after;
    for (int i = 0; i < 64; i++) ram[i] = 16'hA000 + 16'(i);
    vecs[0] = '{6'd5,  7'd3,  4'b1111, 16'hA005, 16'hA007, 1'b0};
    vecs[1] = '{6'd62, 7'd4,  4'b1111, 16'hA03E, 16'hA001, 1'b0};
    vecs[2] = '{6'd20, 7'd8,  4'b1001, 16'hA014, 16'hA01B, 1'b1};
    vecs[3] = '{6'd0,  7'd64, 4'b1111, 16'hA000, 16'hA03F, 1'b0};
    vecs[4] = '{6'd7,  7'd0,  4'b1111, 16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{6'd63, 7'd1,  4'b0101, 16'hA03F, 16'hA03F, 1'b1};
    vecs[6] = '{6'd40, 7'd5,  4'b0011, 16'hA028, 16'hA02C, 1'b0};
    after   = '{6'd30, 7'd2,  4'b1111, 16'hA01E, 16'hA01F, 1'b0};

    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Reset partway through a 10-word burst
    @(negedge clock);
    start = 1'b1; start_addr = 6'd10; count = 7'd10; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    xf = 0;
    for (int k = 0; k < 30 && xf < 3; k++) begin
      if (out_valid && out_ready) xf++;
      @(negedge clock);
    end
    chk("abort_words_before", xf, 3);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_address", mem_address, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_out_data", out_data, 0);
    @(negedge clock);
    reset = 1'b0;
    dcnt = 0; vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dcnt++;
      if (out_valid || busy) vcnt++;
      @(negedge clock);
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_quiet", vcnt, 0);
    run_burst(after);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
